// File: rtl/br_stat_regs.sv
// -----------------------------------------------------------------------------
// br_stat_regs
//
// Branch-predictor statistics block. Three saturating 32-bit event counters
// (resolved branches, BTB hits, mispredictions) sit behind an 8-word
// memory-mapped register window on the CPU's external data bus.
//
// Register map (word offset from BASE):
//   0 CTRL      bit0 EN (R/W), bit1 CLR (write-1 pulse, reads 0)
//   1 STATUS    bits[2:0] sticky saturation flags {MISPR,HIT,BR}, W1C
//   2/3 BR_LO/BR_HI   4/5 HIT_LO/HIT_HI   6/7 MISPR_LO/MISPR_HI
//
// A *_LO read returns live bits [15:0] and captures bits [31:16] of the same
// counter into one shared shadow register; *_HI reads return the shadow. This
// gives software a coherent 32-bit value when it reads LO then HI.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   addr          CPU external data address
//   mm_re         CPU external read strobe
//   mm_we         CPU external write strobe
//   wdata         CPU store data
//   rdata         combinational read data, 0 when not selected (OR-able)
//   inc_br_cnt    resolved branch this cycle
//   inc_hit_cnt   BTB-correct prediction this cycle
//   inc_mispr_cnt misprediction this cycle
// -----------------------------------------------------------------------------
module br_stat_regs #(
    parameter logic [15:0] BASE = 16'hC000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        mm_re,
    input  logic        mm_we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic        inc_br_cnt,
    input  logic        inc_hit_cnt,
    input  logic        inc_mispr_cnt
);

    localparam logic [2:0]  OFF_CTRL     = 3'd0;
    localparam logic [2:0]  OFF_STATUS   = 3'd1;
    localparam logic [2:0]  OFF_BR_LO    = 3'd2;
    localparam logic [2:0]  OFF_BR_HI    = 3'd3;
    localparam logic [2:0]  OFF_HIT_LO   = 3'd4;
    localparam logic [2:0]  OFF_HIT_HI   = 3'd5;
    localparam logic [2:0]  OFF_MISPR_LO = 3'd6;
    localparam logic [2:0]  OFF_MISPR_HI = 3'd7;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // -------------------------------------------------------------------------
    // Saturation helpers
    // -------------------------------------------------------------------------
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc);
        if (inc && (cnt != CNT_MAX))
            return cnt + 32'd1;
        else
            return cnt;
    endfunction

    // An increment attempted while already at the ceiling is the overflow event.
    function automatic logic sat_hit(input logic [31:0] cnt, input logic inc);
        return inc && (cnt == CNT_MAX);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0] br_cnt;
    logic [31:0] hit_cnt;
    logic [31:0] mispr_cnt;
    logic [15:0] shadow;
    logic [2:0]  status;
    logic        en;

    logic [31:0] br_nxt;
    logic [31:0] hit_nxt;
    logic [31:0] mispr_nxt;
    logic [15:0] shadow_nxt;
    logic [2:0]  status_nxt;
    logic        en_nxt;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic       sel;
    logic [2:0] off;
    logic       rd;
    logic       wr;
    logic       wr_ctrl;
    logic       wr_status;
    logic       clr;
    logic       rd_lo;
    logic [2:0] inc_vec;
    logic [2:0] sat_evt;

    assign sel       = (addr[15:3] == BASE[15:3]);
    assign off       = addr[2:0];
    assign rd        = mm_re && sel;
    assign wr        = mm_we && sel;
    assign wr_ctrl   = wr && (off == OFF_CTRL);
    assign wr_status = wr && (off == OFF_STATUS);
    assign clr       = wr_ctrl && wdata[1];
    assign rd_lo     = rd && ((off == OFF_BR_LO) || (off == OFF_HIT_LO) ||
                              (off == OFF_MISPR_LO));

    // Increments are gated by the EN value held before this edge, so a CTRL
    // write that changes EN takes effect from the following cycle.
    assign inc_vec = {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} & {3{en}};

    assign sat_evt = {sat_hit(mispr_cnt, inc_vec[2]),
                      sat_hit(hit_cnt,   inc_vec[1]),
                      sat_hit(br_cnt,    inc_vec[0])};

    // Only the low bits of wdata carry meaning for writable registers.
    logic unused_wdata;
    assign unused_wdata = ^wdata[15:3];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Clear has priority over any coincident increment.
        br_nxt     = clr ? 32'd0 : sat_inc(br_cnt,    inc_vec[0]);
        hit_nxt    = clr ? 32'd0 : sat_inc(hit_cnt,   inc_vec[1]);
        mispr_nxt  = clr ? 32'd0 : sat_inc(mispr_cnt, inc_vec[2]);

        en_nxt     = wr_ctrl ? wdata[0] : en;

        // W1C, but a new saturation event in the same cycle keeps the flag set.
        status_nxt = (status & ~(wdata[2:0] & {3{wr_status}})) | sat_evt;

        // Shadow captures the pre-increment upper half of the counter whose
        // LO word is being read.
        shadow_nxt = shadow;
        if (clr) begin
            shadow_nxt = 16'd0;
        end else if (rd_lo) begin
            case (off)
                OFF_BR_LO:    shadow_nxt = br_cnt[31:16];
                OFF_HIT_LO:   shadow_nxt = hit_cnt[31:16];
                OFF_MISPR_LO: shadow_nxt = mispr_cnt[31:16];
                default:      shadow_nxt = shadow;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt    <= 32'd0;
            hit_cnt   <= 32'd0;
            mispr_cnt <= 32'd0;
            shadow    <= 16'd0;
            status    <= 3'd0;
            en        <= 1'b1;
        end else begin
            br_cnt    <= br_nxt;
            hit_cnt   <= hit_nxt;
            mispr_cnt <= mispr_nxt;
            shadow    <= shadow_nxt;
            status    <= status_nxt;
            en        <= en_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux: combinational, zero when not selected so it can be OR-combined.
    // -------------------------------------------------------------------------
    always_comb begin
        rdata = 16'h0000;
        if (rd) begin
            case (off)
                OFF_CTRL:     rdata = {15'd0, en};
                OFF_STATUS:   rdata = {13'd0, status};
                OFF_BR_LO:    rdata = br_cnt[15:0];
                OFF_BR_HI:    rdata = shadow;
                OFF_HIT_LO:   rdata = hit_cnt[15:0];
                OFF_HIT_HI:   rdata = shadow;
                OFF_MISPR_LO: rdata = mispr_cnt[15:0];
                OFF_MISPR_HI: rdata = shadow;
                default:      rdata = 16'h0000;
            endcase
        end
    end

endmodule
